fetch_unit: RTL
===============

# fetch_unit

Instruction fetch and sequencing block for the single-cycle CPU. It requests 32-bit instruction words from instruction memory over a req/ack handshake and presents the 8-bit opcode to the control unit. It then consumes the control unit's `jmp`, `jmp_if` and `halt` decisions to form the next program counter. It sits between instruction memory and the control unit/execute datapath, and owns the PC, the run/halt state and the retired-instruction count.

## Interface
Parameters:
- `PC_W`, 8, program counter / instruction memory address width.
- `RESET_PC`, 0, PC value loaded on reset and on restart from HALTED.
- `TIMEOUT_CYCLES`, 255, fetch watchdog limit; used only with `FETCH_UNIT_TIMEOUT_EN`.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  run request, honoured only in IDLE or HALTED.
- `imem_req`  out  1  instruction read request.
- `imem_addr`  out  PC_W  read address; equals `pc`.
- `imem_ack`  in  1  read complete; `imem_rdata` is valid in the same cycle.
- `imem_rdata`  in  32  instruction word.
- `instr`  out  32  latched instruction word.
- `opcode`  out  8  `instr[31:24]`, driven to the control unit.
- `instr_valid`  out  1  `instr`/`opcode` are valid and offered to execute.
- `exec_ready`  in  1  execute accepts (retires) the offered instruction.
- `jmp`, `jmp_if`, `halt`  in  1 each  decoded from `opcode` by the control unit.
- `cond_flag`  in  1  ALU condition result for `jmp_if`.
- `pc`  out  PC_W  current program counter.
- `halted`  out  1  high in HALTED.
- `fault`  out  1  fetch timeout occurred; tied 0 without the macro.
- `retired`  out  16  count of retired instructions.

## Operation
- States: IDLE, FETCH, ISSUE, HALTED.
- IDLE:
  - `start`=1 → FETCH.
  - Otherwise the block stays in IDLE.
- FETCH:
  - `imem_req`=1 and `imem_addr`=`pc`.
  - On `imem_ack`=1: `instr` ← `imem_rdata`, then → ISSUE.
  - Without `imem_ack` the block stays in FETCH.
- ISSUE:
  - `instr_valid`=1 and `instr` is held stable.
  - On `exec_ready`=1 the instruction retires: `retired` += 1 (wraps from 16'hFFFF to 0). `jmp`, `jmp_if`, `halt` and `cond_flag` are sampled only in this cycle.
  - Next-PC priority:
    - `halt`: `pc` is unchanged, → HALTED, `halted`=1.
    - `jmp`: `pc` ← `instr[PC_W-1:0]`, → FETCH.
    - `jmp_if` && `cond_flag`: `pc` ← `instr[PC_W-1:0]`, → FETCH.
    - Otherwise: `pc` ← `pc`+1 modulo 2^PC_W (wraps from all-ones to 0), → FETCH.
  - `jmp` and `jmp_if` both high resolves to `jmp`. `halt` overrides both.
- HALTED:
  - `start`=1: `pc` ← `RESET_PC`, `halted`=0, `fault`=0, → FETCH. `retired` is kept.
- `start` is ignored in FETCH and ISSUE.
- `imem_ack` is ignored when `imem_req`=0.
- Opcode 8'h00 and undefined opcodes retire as no-ops and advance `pc` by 1.

## Timing
- Reset values: state=IDLE, `pc`=`RESET_PC`, `imem_req`=0, `instr`=0 (so `opcode`=8'h00), `instr_valid`=0, `halted`=0, `fault`=0, `retired`=0.
- Reset is asynchronous. Assertion in mid-fetch or mid-issue immediately drops `imem_req` and `instr_valid`; an in-flight ack is lost.
- All outputs are registered except `opcode` (a slice of the `instr` register) and `imem_addr` (equals the `pc` register).
- `start` in cycle N → `imem_req`=1 in N+1.
- `imem_ack` in cycle M → `instr_valid`=1 and `imem_req`=0 in M+1.
- Retire in cycle K → `imem_req`=1 with the new `pc` in K+1.
- Peak throughput with zero-wait memory and `exec_ready` tied 1: one instruction per 2 cycles.

## Configuration
- `FETCH_UNIT_TIMEOUT_EN` defined:
  - A counter clears on entry to FETCH and increments each FETCH cycle without `imem_ack`.
  - When it reaches `TIMEOUT_CYCLES`: → HALTED, `fault`=1, `halted`=1, `imem_req`=0 on the next cycle.
  - An ack arriving in the same cycle as the limit wins; no fault is raised.
- `FETCH_UNIT_TIMEOUT_EN` not defined:
  - No counter is built; FETCH waits indefinitely and `fault` is constant 0.

## Test plan
- Reset, then `start` pulse. Memory holds 03,03,06,FF at addresses 0..3 with zero-wait ack → opcodes issued in order 03,03,06,FF; `halted`=1 with `pc`=3; `retired`=4; cycle from `start` to `halted` = 9.
- Opcode 0E with `instr[7:0]`=8'h20 → next `imem_addr`=8'h20.
- Opcode 0F at `pc`=5 with target 8'h40: `cond_flag`=0 → `imem_addr`=6; `cond_flag`=1 → `imem_addr`=8'h40.
- `pc`=8'hFF with non-jump opcode 01 → next `imem_addr`=8'h00. `exec_ready` held low for 5 cycles → `instr_valid` and `opcode` stay stable for 5 cycles and `retired` does not change.
- `rst_n` pulsed low while in ISSUE with `retired`=7 → `instr_valid`=0, `pc`=`RESET_PC` and `retired`=0 immediately, with no clock edge. After `start` post-HALTED: `pc`=`RESET_PC`, `retired` kept.
- With `FETCH_UNIT_TIMEOUT_EN`, `TIMEOUT_CYCLES`=4 and `imem_ack` never asserted → `fault`=1 and `halted`=1 after the 4th FETCH cycle. A following `start` clears `fault` and refetches from `RESET_PC`.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC, fetches instruction words over req/ack and issues them to execute.
// Optional fetch watchdog is built when FETCH_UNIT_TIMEOUT_EN is defined.
module fetch_unit #(
    parameter int unsigned PC_W           = 8,
    parameter int unsigned RESET_PC       = 0,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     instr,
    output logic [7:0]      opcode,
    output logic            instr_valid,
    input  logic            exec_ready,
    input  logic            jmp,
    input  logic            jmp_if,
    input  logic            halt,
    input  logic            cond_flag,
    output logic [PC_W-1:0] pc,
    output logic            halted,
    output logic            fault,
    output logic [15:0]     retired
);
    localparam int unsigned RET_W = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        ISSUE  = 2'd2,
        HALTED = 2'd3
    } state_t;

    state_t          state;
    logic            timeout_c;
    logic            take_branch_c;
    logic [PC_W-1:0] branch_target_c;

    assign opcode          = instr[31:24];
    assign imem_addr       = pc;
    // jmp wins over jmp_if; halt is resolved ahead of both in the FSM
    assign take_branch_c   = jmp | (jmp_if & cond_flag);
    assign branch_target_c = instr[PC_W-1:0];

`ifdef FETCH_UNIT_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] to_cnt;

    // Counts ack-less FETCH cycles; cleared whenever we are outside FETCH
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt <= '0;
        end else if (state != FETCH) begin
            to_cnt <= '0;
        end else if (!imem_ack) begin
            to_cnt <= to_cnt + TO_W'(1);
        end
    end

    // An ack in the limit cycle takes precedence over the timeout
    assign timeout_c = (state == FETCH) && !imem_ack &&
                       (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_c = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc          <= PC_W'(RESET_PC);
            imem_req    <= 1'b0;
            instr       <= '0;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
            fault       <= 1'b0;
            retired     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= FETCH;
                        imem_req <= 1'b1;
                    end
                end
                FETCH: begin
                    if (imem_ack) begin
                        state       <= ISSUE;
                        imem_req    <= 1'b0;
                        instr       <= imem_rdata;
                        instr_valid <= 1'b1;
                    end else if (timeout_c) begin
                        state    <= HALTED;
                        imem_req <= 1'b0;
                        halted   <= 1'b1;
                        fault    <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (exec_ready) begin
                        instr_valid <= 1'b0;
                        retired     <= retired + RET_W'(1);
                        if (halt) begin
                            state  <= HALTED;
                            halted <= 1'b1;
                        end else begin
                            state    <= FETCH;
                            imem_req <= 1'b1;
                            pc       <= take_branch_c ? branch_target_c : pc + PC_W'(1);
                        end
                    end
                end
                HALTED: begin
                    // Restart keeps the retired count
                    if (start) begin
                        state    <= FETCH;
                        imem_req <= 1'b1;
                        pc       <= PC_W'(RESET_PC);
                        halted   <= 1'b0;
                        fault    <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
